// File: rtl/spike_event_bridge_if.sv
// spike_event_bridge_if
// Downstream spike-event handshake bundle (valid/ready plus spike address).
//   valid : source has a spike on addr
//   addr  : spike neuron address
//   ready : sink accepts the spike; a transfer happens when valid && ready
// Modports: master = spike source (bridge side), slave = spike consumer.
interface spike_event_bridge_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  valid;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;

  modport master (output valid, output addr, input ready);
  modport slave  (input valid, input addr, output ready);
endinterface

// File: rtl/spike_event_bridge.sv
// spike_event_bridge
// Buffers a valid-only spike stream from an SNN core and forwards it over a
// valid/ready handshake, signalling a timestep boundary once every spike of
// the closed timestep has been handed off.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   i_spike_in_valid/addr: upstream spike strobe and address (no backpressure)
//   i_timestep_done      : upstream one-cycle timestep-finished pulse
//   spike_event (master) : downstream valid/addr/ready handshake
//   o_timestep_done      : one-cycle pulse, closed timestep fully delivered
//   o_fifo_count         : registered occupancy (includes output register)
//   o_overflow           : sticky, a spike was dropped
//   o_drop_count         : saturating dropped-spike count
//   o_proto_err          : sticky, timestep pulse received while not idle
//   i_clear_status       : synchronous clear of the status flags
// Optional build macro: SPIKE_ADDR_REMAP_EN adds ADDR_OFFSET to each address
// at enqueue (modulo 2^ADDR_WIDTH); without it addresses pass unchanged.
module spike_event_bridge #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DEPTH       = 64,
  parameter int CNT_WIDTH   = 16,
  parameter int ADDR_OFFSET = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_spike_in_valid,
  input  logic [ADDR_WIDTH-1:0]   i_spike_in_addr,
  input  logic                    i_timestep_done,
  spike_event_bridge_if.master    spike_event,
  output logic                    o_timestep_done,
  output logic [$clog2(DEPTH):0]  o_fifo_count,
  output logic                    o_overflow,
  output logic [CNT_WIDTH-1:0]    o_drop_count,
  output logic                    o_proto_err,
  input  logic                    i_clear_status
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Storage RAM; the output register holds one more entry.
  logic [ADDR_WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic                  proto_err_q, proto_err_d;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  pend_q;
  logic                  ts_done_q;

  logic                  pop_s, full_s, drop_s, accept_s, mem_we_s, proto_set_s;
  logic [CW-1:0]         ram_cnt_s;
  logic [ADDR_WIDTH-1:0] wdata_s;

`ifdef SPIKE_ADDR_REMAP_EN
  assign wdata_s = i_spike_in_addr + ADDR_WIDTH'(ADDR_OFFSET);
`else
  logic unused_offset_s;
  assign unused_offset_s = ^ADDR_OFFSET;
  assign wdata_s         = i_spike_in_addr;
`endif

  // Buffer control: push/pop decisions, output-stage refill and occupancy.
  always_comb begin
    pop_s       = out_valid_q & spike_event.ready;
    full_s      = (cnt_q == CW'(DEPTH));
    drop_s      = i_spike_in_valid & full_s & ~pop_s;
    accept_s    = i_spike_in_valid & ~drop_s;
    // RAM holds everything except the entry sitting in the output register.
    ram_cnt_s   = cnt_q - {{(CW-1){1'b0}}, out_valid_q};
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_we_s    = 1'b0;
    if (!out_valid_q || pop_s) begin
      if (ram_cnt_s != {CW{1'b0}}) begin
        out_valid_d = 1'b1;
        out_addr_d  = mem_q[rd_ptr_q];
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        mem_we_s    = accept_s;
      end else if (accept_s) begin
        // Empty RAM: bypass straight into the output register.
        out_valid_d = 1'b1;
        out_addr_d  = wdata_s;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      mem_we_s = accept_s;
    end
    if (mem_we_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({accept_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Sticky status: a drop or protocol error wins over a same-cycle clear.
  always_comb begin
    proto_set_s = i_timestep_done & (state_q != ST_IDLE);
    if (drop_s) begin
      overflow_d = 1'b1;
      if (i_clear_status) begin
        drop_count_d = CNT_WIDTH'(1);
      end else if (&drop_count_q) begin
        drop_count_d = drop_count_q;
      end else begin
        drop_count_d = drop_count_q + CNT_WIDTH'(1);
      end
    end else if (i_clear_status) begin
      overflow_d   = 1'b0;
      drop_count_d = {CNT_WIDTH{1'b0}};
    end else begin
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;
    end
    if (proto_set_s) begin
      proto_err_d = 1'b1;
    end else if (i_clear_status) begin
      proto_err_d = 1'b0;
    end else begin
      proto_err_d = proto_err_q;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q     <= {PTR_W{1'b0}};
      wr_ptr_q     <= {PTR_W{1'b0}};
      cnt_q        <= {CW{1'b0}};
      out_valid_q  <= 1'b0;
      out_addr_q   <= {ADDR_WIDTH{1'b0}};
      overflow_q   <= 1'b0;
      drop_count_q <= {CNT_WIDTH{1'b0}};
      proto_err_q  <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_addr_q   <= out_addr_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Spike storage RAM (contents need no reset; pointers qualify them).
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  // Timestep FSM: pend counts the closed timestep's spikes still to leave.
  // Because the buffer is in order, the first pend pops are exactly those.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_q    <= {CNT_WIDTH{1'b0}};
      ts_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ts_done_q <= 1'b0;
          if (i_timestep_done) begin
            // cnt_d already counts the same-cycle push and pop.
            if (cnt_d == {CW{1'b0}}) begin
              state_q   <= ST_DONE;
              ts_done_q <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
              pend_q  <= CNT_WIDTH'(cnt_d);
            end
          end
        end
        ST_DRAIN: begin
          ts_done_q <= 1'b0;
          if (pop_s) begin
            pend_q <= pend_q - CNT_WIDTH'(1);
            if (pend_q == CNT_WIDTH'(1)) begin
              state_q   <= ST_DONE;
              ts_done_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          ts_done_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          ts_done_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign spike_event.valid = out_valid_q;
  assign spike_event.addr  = out_addr_q;
  assign o_timestep_done   = ts_done_q;
  assign o_fifo_count      = cnt_q;
  assign o_overflow        = overflow_q;
  assign o_drop_count      = drop_count_q;
  assign o_proto_err       = proto_err_q;
endmodule

// File: tb/tb_spike_event_bridge.sv
// tb_spike_event_bridge
// Directed stimulus against spike_event_bridge with a queue-based reference
// model (each buffered spike tagged with its timestep) checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_spike_event_bridge;
  localparam int AW     = 14;
  localparam int DEPTH  = 64;
  localparam int CNTW   = 16;
  localparam int OFFSET = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic            push;
  logic [AW-1:0]   paddr;
  logic            ts_in;
  logic            clr;
  logic            ready;
  logic            done_o;
  logic [6:0]      count_o;
  logic            ovf_o;
  logic [CNTW-1:0] drop_o;
  logic            proto_o;

  int total = 0;
  int bad   = 0;

  spike_event_bridge_if #(.ADDR_WIDTH(AW)) ev_if ();
  assign ev_if.ready = ready;

  spike_event_bridge #(
    .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW), .ADDR_OFFSET(OFFSET)
  ) dut (
    .clk(clk), .rst(rst),
    .i_spike_in_valid(push), .i_spike_in_addr(paddr),
    .i_timestep_done(ts_in),
    .spike_event(ev_if),
    .o_timestep_done(done_o), .o_fifo_count(count_o),
    .o_overflow(ovf_o), .o_drop_count(drop_o), .o_proto_err(proto_o),
    .i_clear_status(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] remap(input logic [AW-1:0] a);
`ifdef SPIKE_ADDR_REMAP_EN
    return AW'(a + AW'(OFFSET));
`else
    return a;
`endif
  endfunction

  // ---------------- reference model ----------------
  logic [AW-1:0] q_addr[$];
  int            q_ts[$];
  int            cur_ts, closing_ts, m_drop;
  bit            m_drain, m_done, m_ovf, m_proto;

  function automatic bit has_old(input int c);
    foreach (q_ts[i]) if (q_ts[i] <= c) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q_addr.delete(); q_ts.delete();
        cur_ts = 0; closing_ts = 0; m_drop = 0;
        m_drain = 0; m_done = 0; m_ovf = 0; m_proto = 0;
      end else begin
        bit pop, drop, pset;
        pop  = (q_addr.size() > 0) && ready;
        drop = push && (q_addr.size() == DEPTH) && !pop;
        pset = ts_in && (m_drain || m_done);
        if (pop) begin
          void'(q_addr.pop_front());
          void'(q_ts.pop_front());
        end
        if (push && !drop) begin
          q_addr.push_back(remap(paddr));
          q_ts.push_back(cur_ts);
        end
        if (m_done) begin
          m_done = 0;
        end else if (m_drain) begin
          if (!has_old(closing_ts)) begin
            m_drain = 0;
            m_done  = 1;
          end
        end else if (ts_in) begin
          closing_ts = cur_ts;
          cur_ts++;
          if (has_old(closing_ts)) m_drain = 1;
          else m_done = 1;
        end
        if (drop) begin
          m_ovf  = 1;
          m_drop = clr ? 1 : ((m_drop == 65535) ? 65535 : m_drop + 1);
        end else if (clr) begin
          m_ovf  = 0;
          m_drop = 0;
        end
        if (pset) m_proto = 1;
        else if (clr) m_proto = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("valid", 32'(ev_if.valid), 32'(q_addr.size() > 0));
      if (q_addr.size() > 0) chk("addr", 32'(ev_if.addr), 32'(q_addr[0]));
      chk("count", 32'(count_o), 32'(q_addr.size()));
      chk("ts_done", 32'(done_o), 32'(m_done));
      chk("overflow", 32'(ovf_o), 32'(m_ovf));
      chk("drop_count", 32'(drop_o), 32'(m_drop));
      chk("proto_err", 32'(proto_o), 32'(m_proto));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n_done, done_k;
    rst = 1'b1; push = 1'b0; paddr = '0; ts_in = 1'b0; clr = 1'b0; ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 32'(ev_if.valid), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    rst = 1'b0;

    // Single spike, latency 1.
    ready = 1'b1; push = 1'b1; paddr = 14'h0123;
    tick(); push = 1'b0;
    chk("t1_valid", 32'(ev_if.valid), 32'd1);
    chk("t1_addr", 32'(ev_if.addr), 32'(remap(14'h0123)));
    tick();
    chk("t1_count", 32'(count_o), 32'd0);

    // Backpressure: 5 spikes held, then drained in order.
    ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push = 1'b1; paddr = AW'(i); tick();
    end
    push = 1'b0;
    chk("t2_count", 32'(count_o), 32'd5);
    tick(); tick();
    chk("t2_hold", 32'(ev_if.addr), 32'(remap(14'd1)));
    ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("t2_order", 32'(ev_if.addr), 32'(remap(AW'(i))));
      tick();
    end
    ready = 1'b0;
    chk("t2_empty", 32'(count_o), 32'd0);

    // Overflow, push+pop while full, drop vs clear priority.
    for (int i = 0; i < 70; i++) begin
      push = 1'b1; paddr = AW'(i); tick();
    end
    push = 1'b0;
    chk("t3_count", 32'(count_o), 32'd64);
    chk("t3_ovf", 32'(ovf_o), 32'd1);
    chk("t3_drop", 32'(drop_o), 32'd6);
    push = 1'b1; paddr = 14'd500; ready = 1'b1; tick();
    push = 1'b0; ready = 1'b0;
    chk("t3_full_pushpop_cnt", 32'(count_o), 32'd64);
    chk("t3_full_pushpop_drop", 32'(drop_o), 32'd6);
    push = 1'b1; clr = 1'b1; tick();
    push = 1'b0; clr = 1'b0;
    chk("t3_clr_drop_ovf", 32'(ovf_o), 32'd1);
    chk("t3_clr_drop_cnt", 32'(drop_o), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3_clr_ovf", 32'(ovf_o), 32'd0);
    chk("t3_clr_cnt", 32'(drop_o), 32'd0);
    ready = 1'b1;
    repeat (70) tick();
    ready = 1'b0;
    chk("t3_drained", 32'(count_o), 32'd0);

    // Timestep drain: 3 spikes, 4th with the timestep pulse, 2 more after.
    for (int i = 10; i <= 12; i++) begin
      push = 1'b1; paddr = AW'(i); tick();
    end
    paddr = 14'd13; ts_in = 1'b1; tick();
    ts_in = 1'b0; ready = 1'b1;
    n_done = 0; done_k = 0;
    for (int k = 1; k <= 8; k++) begin
      push  = (k <= 2);
      paddr = (k == 1) ? 14'd20 : 14'd21;
      tick();
      if (done_o) begin n_done++; done_k = k; end
      if (k == 4) chk("t4_after_addr20", 32'(ev_if.addr), 32'(remap(14'd20)));
      if (k == 5) chk("t4_after_addr21", 32'(ev_if.addr), 32'(remap(14'd21)));
    end
    push = 1'b0; ready = 1'b0;
    chk("t4_done_cycle", 32'(done_k), 32'd4);
    chk("t4_done_pulses", 32'(n_done), 32'd1);

    // Empty timestep, then protocol error while draining.
    ts_in = 1'b1; tick(); ts_in = 1'b0;
    chk("t5_empty_done", 32'(done_o), 32'd1);
    tick();
    chk("t5_empty_done_off", 32'(done_o), 32'd0);
    for (int i = 0; i < 2; i++) begin
      push = 1'b1; paddr = AW'(30 + i); tick();
    end
    push = 1'b0;
    ts_in = 1'b1; tick();
    tick(); ts_in = 1'b0;
    chk("t5_proto", 32'(proto_o), 32'd1);
    ready = 1'b1; n_done = 0;
    repeat (6) begin tick(); if (done_o) n_done++; end
    ready = 1'b0;
    chk("t5_one_pulse", 32'(n_done), 32'd1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t5_proto_clr", 32'(proto_o), 32'd0);

    // Reset in the middle of a drain.
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; paddr = AW'(40 + i); tick();
    end
    push = 1'b0;
    ts_in = 1'b1; tick(); tick(); ts_in = 1'b0;
    chk("t6_pre_proto", 32'(proto_o), 32'd1);
    rst = 1'b1; #1;
    chk("t6_rst_valid", 32'(ev_if.valid), 32'd0);
    chk("t6_rst_count", 32'(count_o), 32'd0);
    chk("t6_rst_proto", 32'(proto_o), 32'd0);
    chk("t6_rst_done", 32'(done_o), 32'd0);
    tick(); tick();
    rst = 1'b0; ready = 1'b1; n_done = 0;
    repeat (8) begin tick(); if (done_o) n_done++; end
    chk("t6_no_pulse", 32'(n_done), 32'd0);
    chk("t6_empty", 32'(ev_if.valid), 32'd0);

    // Address remap (or pass-through in the default build).
    push = 1'b1; paddr = 14'd16380; tick(); push = 1'b0;
`ifdef SPIKE_ADDR_REMAP_EN
    chk("t7_remap", 32'(ev_if.addr), 32'd96);
`else
    chk("t7_passthru", 32'(ev_if.addr), 32'd16380);
`endif
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spike_event_bridge.md
Name: spike_event_bridge

Overview:
- Sits at the output spike interface of an SNN core and receives the core's valid-only spike stream (address plus valid pulse).
- Buffers the spikes and forwards them to a downstream consumer, typically the next core's input spike event port, over a valid/ready handshake.
- Tracks timestep boundaries: it signals downstream only after every spike from a completed timestep has been handed off.

Parameters:
ADDR_WIDTH, 14, spike address width
DEPTH, 64, buffer occupancy limit in entries (power of 2, >= 4); includes the output register
CNT_WIDTH, 16, width of drop counter and drain counter
ADDR_OFFSET, 0, address offset added when SPIKE_ADDR_REMAP_EN is defined

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
i_spike_in_valid  input  1  upstream spike strobe, one spike per cycle, no backpressure
i_spike_in_addr  input  ADDR_WIDTH  upstream spike neuron address
i_timestep_done  input  1  one-cycle pulse from upstream: timestep finished
o_spike_event_valid  input/output: output  1  downstream spike valid
o_spike_event_addr  output  ADDR_WIDTH  downstream spike address
i_spike_event_ready  input  1  downstream ready
o_timestep_done  output  1  one-cycle pulse: all spikes of the closed timestep delivered
o_fifo_count  output  $clog2(DEPTH)+1  current occupancy
o_overflow  output  1  sticky: a spike was dropped
o_drop_count  output  CNT_WIDTH  dropped spikes, saturating
o_proto_err  output  1  sticky: i_timestep_done received while not IDLE
i_clear_status  input  1  synchronous clear of o_overflow, o_drop_count, o_proto_err

Behaviour:
- Reset: every output is 0, the buffer is empty and the FSM is in IDLE. Reset asserted mid-operation discards all buffered spikes and any pending timestep, with no done pulse.
- Buffer: circular RAM plus a registered output stage (first-word fall-through).
  - A spike written into an empty bridge appears on o_spike_event_valid/addr the next cycle: latency 1.
  - o_spike_event_addr stays stable while valid && !ready.
- Pop: handshake is valid && ready. Push: i_spike_in_valid.
- Full: occupancy == DEPTH.
  - Push while full with no pop in the same cycle: the spike is dropped, o_overflow is set and o_drop_count increments, saturating at all-ones.
  - Push while full with a pop in the same cycle: the spike is accepted.
- Simultaneous push and pop at any other occupancy leaves occupancy unchanged. Pointers wrap modulo DEPTH.
- o_fifo_count is registered and reflects post-update occupancy.
- FSM has three states: IDLE, DRAIN, DONE.
  - IDLE, on i_timestep_done: load pend = occupancy + (accepted push this cycle) - (pop this cycle). The same-cycle spike belongs to the closing timestep. If pend == 0 go to DONE, else go to DRAIN.
  - DRAIN: pend decrements on each pop; when it reaches 0, go to DONE. Spikes arriving during DRAIN are buffered normally but are not counted in pend (they belong to the next timestep).
  - DONE: o_timestep_done = 1 for exactly one cycle, then return to IDLE.
  - i_timestep_done in DRAIN or DONE is ignored and sets o_proto_err.
- i_clear_status clears the status flags the following cycle. A drop in the same cycle as the clear takes priority: o_overflow ends up 1 and o_drop_count ends up 1.

Optional Feature:
- SPIKE_ADDR_REMAP_EN defined: the address is stored as (i_spike_in_addr + ADDR_OFFSET) mod 2^ADDR_WIDTH, computed at enqueue with no added latency.
- Undefined: the address passes through unchanged and ADDR_OFFSET is unused.

Test Plan:
- Single spike: addr 0x0123 pushed with ready=1 -> o_spike_event_valid=1, addr 0x0123 exactly 1 cycle later; o_fifo_count returns to 0.
- Backpressure: push 5 spikes (addr 1..5) with ready=0 -> count=5, addr=1 held stable. Raise ready -> addresses 1,2,3,4,5 emitted in order on consecutive cycles.
- Overflow: DEPTH=64, ready=0, push 70 spikes -> count=64, o_overflow=1, o_drop_count=6. Pulse i_clear_status -> both flags 0.
- Timestep drain:
  - Setup: 3 buffered spikes, then i_timestep_done together with a 4th spike; 2 further spikes follow; ready=1 from the next cycle.
  - Required: o_timestep_done pulses 1 cycle after the 4th spike's handshake. The later 2 spikes are still delivered after the pulse.
- Empty timestep / protocol error:
  - i_timestep_done with an empty buffer -> o_timestep_done 1 cycle later.
  - A second i_timestep_done while in DRAIN -> o_proto_err=1 and only one done pulse.
- Mid-operation reset / remap:
  - rst asserted with 10 spikes buffered while in DRAIN -> all outputs 0 immediately and no done pulse.
  - With SPIKE_ADDR_REMAP_EN and ADDR_OFFSET=100, input addr 16380 -> output addr 96.
